// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin set, amount width and FSM states.
package change_dispenser_pkg;

    localparam int K_NUM_COINS  = 3;
    localparam int K_TOTAL_BITS = 31;

    localparam int unsigned K_COIN_100  = 100;
    localparam int unsigned K_COIN_500  = 500;
    localparam int unsigned K_COIN_1000 = 1000;

    // One-hot coin encodings as seen on o_return_coin
    localparam logic [K_NUM_COINS-1:0] COIN_OH_NONE = 3'b000;
    localparam logic [K_NUM_COINS-1:0] COIN_OH_100  = 3'b001;
    localparam logic [K_NUM_COINS-1:0] COIN_OH_500  = 3'b010;
    localparam logic [K_NUM_COINS-1:0] COIN_OH_1000 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin pick: largest denomination that fits the remaining amount and is in stock.
module coin_selector
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W   = K_TOTAL_BITS,
    parameter int STOCK_W = 8
) (
    input  logic [AMT_W-1:0]       i_remaining,
    input  logic [STOCK_W-1:0]     i_stock0,
    input  logic [STOCK_W-1:0]     i_stock1,
    input  logic [STOCK_W-1:0]     i_stock2,
    output logic [K_NUM_COINS-1:0] o_coin,
    output logic [AMT_W-1:0]       o_value,
    output logic                   o_found
);

    localparam logic [AMT_W-1:0] W_V100  = AMT_W'(K_COIN_100);
    localparam logic [AMT_W-1:0] W_V500  = AMT_W'(K_COIN_500);
    localparam logic [AMT_W-1:0] W_V1000 = AMT_W'(K_COIN_1000);

    always_comb begin
        o_coin  = COIN_OH_NONE;
        o_value = '0;
        o_found = 1'b0;
        if ((i_remaining >= W_V1000) && (i_stock2 != '0)) begin
            o_coin  = COIN_OH_1000;
            o_value = W_V1000;
            o_found = 1'b1;
        end else if ((i_remaining >= W_V500) && (i_stock1 != '0)) begin
            o_coin  = COIN_OH_500;
            o_value = W_V500;
            o_found = 1'b1;
        end else if ((i_remaining >= W_V100) && (i_stock0 != '0)) begin
            o_coin  = COIN_OH_100;
            o_value = W_V100;
            o_found = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: returns an amount as a stream of one-hot coins from a finite stock.
//   state    | meaning
//   IDLE     | ready for a return request
//   SELECT   | pick the next coin, or finish when nothing fits
//   DISPENSE | coin presented, waiting for the chute handshake
//   DONE     | one-cycle completion pulse with shortfall
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W      = K_TOTAL_BITS,
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [AMT_W-1:0]       i_return_amount,
    output logic [K_NUM_COINS-1:0] o_return_coin,
    output logic                   o_coin_valid,
    input  logic                   i_coin_ready,
    input  logic [K_NUM_COINS-1:0] i_refill,
    output logic                   o_done,
    output logic [AMT_W-1:0]       o_shortfall,
    output logic [STOCK_W-1:0]     o_stock0,
    output logic [STOCK_W-1:0]     o_stock1,
    output logic [STOCK_W-1:0]     o_stock2
);

    localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [AMT_W-1:0]         r_remaining;
    logic [K_NUM_COINS-1:0]   r_return_coin;
    logic [AMT_W-1:0]         r_coin_value;
    logic                     r_coin_valid;
    logic                     r_done;
    logic [AMT_W-1:0]         r_shortfall;
    logic [STOCK_W-1:0]       r_stock      [K_NUM_COINS];
    logic [STOCK_W-1:0]       w_stock_next [K_NUM_COINS];

    logic [K_NUM_COINS-1:0]   w_sel_coin;
    logic [AMT_W-1:0]         w_sel_value;
    logic                     w_sel_found;
    logic                     w_handshake;
    logic [K_NUM_COINS-1:0]   w_dec;

    coin_selector #(
        .AMT_W   (AMT_W),
        .STOCK_W (STOCK_W)
    ) u_coin_selector (
        .i_remaining (r_remaining),
        .i_stock0    (r_stock[0]),
        .i_stock1    (r_stock[1]),
        .i_stock2    (r_stock[2]),
        .o_coin      (w_sel_coin),
        .o_value     (w_sel_value),
        .o_found     (w_sel_found)
    );

    assign w_handshake = (r_state == ST_DISPENSE) && i_coin_ready;
    assign w_dec       = {K_NUM_COINS{w_handshake}} & r_return_coin;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (i_req_valid) w_state_next = ST_SELECT;
            ST_SELECT:   w_state_next = w_sel_found ? ST_DISPENSE : ST_DONE;
            ST_DISPENSE: if (i_coin_ready) w_state_next = ST_SELECT;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shortfall is captured on the SELECT->DONE edge so it is valid in the same cycle as o_done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining   <= '0;
            r_return_coin <= COIN_OH_NONE;
            r_coin_value  <= '0;
            r_coin_valid  <= 1'b0;
            r_done        <= 1'b0;
            r_shortfall   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_req_valid) begin
                        r_remaining <= i_return_amount;
                    end
                end
                ST_SELECT: begin
                    if (w_sel_found) begin
                        r_return_coin <= w_sel_coin;
                        r_coin_value  <= w_sel_value;
                        r_coin_valid  <= 1'b1;
                    end else begin
                        r_done      <= 1'b1;
                        r_shortfall <= r_remaining;
                    end
                end
                ST_DISPENSE: begin
                    if (i_coin_ready) begin
                        r_remaining   <= r_remaining - r_coin_value;
                        r_return_coin <= COIN_OH_NONE;
                        r_coin_value  <= '0;
                        r_coin_valid  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b0;
                    r_remaining <= '0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    // Refill and dispense of the same coin in one cycle cancel out
    always_comb begin
        for (int i = 0; i < K_NUM_COINS; i++) begin
            w_stock_next[i] = r_stock[i];
            if (i_refill[i] && !w_dec[i]) begin
                if (r_stock[i] != STOCK_MAX) begin
                    w_stock_next[i] = r_stock[i] + STOCK_W'(1);
                end
            end else if (!i_refill[i] && w_dec[i]) begin
                if (r_stock[i] != '0) begin
                    w_stock_next[i] = r_stock[i] - STOCK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K_NUM_COINS; i++) begin
                r_stock[i] <= STOCK_INIT;
            end
        end else begin
            for (int i = 0; i < K_NUM_COINS; i++) begin
                r_stock[i] <= w_stock_next[i];
            end
        end
    end

    assign o_req_ready   = (r_state == ST_IDLE);
    assign o_return_coin = r_return_coin;
    assign o_coin_valid  = r_coin_valid;
    assign o_done        = r_done;
    assign o_shortfall   = r_shortfall;
    assign o_stock0      = r_stock[0];
    assign o_stock1      = r_stock[1];
    assign o_stock2      = r_stock[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy reference model feeds an expectation queue.
module tb_change_dispenser;

    localparam int AMT_W   = 31;
    localparam int STOCK_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_req_valid;
    logic               o_req_ready;
    logic [AMT_W-1:0]   i_return_amount;
    logic [2:0]         o_return_coin;
    logic               o_coin_valid;
    logic               i_coin_ready;
    logic [2:0]         i_refill;
    logic               o_done;
    logic [AMT_W-1:0]   o_shortfall;
    logic [STOCK_W-1:0] o_stock0, o_stock1, o_stock2;

    change_dispenser #(.AMT_W(AMT_W), .STOCK_W(STOCK_W), .INIT_STOCK(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_return_amount (i_return_amount),
        .o_return_coin   (o_return_coin),
        .o_coin_valid    (o_coin_valid),
        .i_coin_ready    (i_coin_ready),
        .i_refill        (i_refill),
        .o_done          (o_done),
        .o_shortfall     (o_shortfall),
        .o_stock0        (o_stock0),
        .o_stock1        (o_stock1),
        .o_stock2        (o_stock2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [2:0]  coin;
        int unsigned shortfall;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_stock[3];
    bit   rnd_ready = 1'b0;
    int   coin_val[3] = '{100, 500, 1000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever a coin handshakes or o_done pulses
    logic [2:0] prev_coin;
    bit         prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold_valid", o_coin_valid, 1);
                chk_eq("hold_coin", o_return_coin, prev_coin);
            end
            if (o_coin_valid) chk_eq("coin_onehot", $countones(o_return_coin), 1);
            else              chk_eq("idle_coin_zero", o_return_coin, 0);
            if (o_coin_valid && i_coin_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_coin: got coin %b expected nothing", o_return_coin);
                end else begin
                    e = sb.pop_front();
                    if (e.is_done) begin
                        total++; bad++;
                        $display("FAIL coin_order: got coin %b expected done", o_return_coin);
                    end else begin
                        chk_eq("coin", o_return_coin, e.coin);
                        if (e.exp_cyc >= 0) chk_eq("coin_cycle", cyc, e.exp_cyc);
                    end
                end
            end
            if (o_done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done expected nothing");
                end else begin
                    e = sb.pop_front();
                    if (!e.is_done) begin
                        total++; bad++;
                        $display("FAIL done_order: got done expected coin %b", e.coin);
                    end else begin
                        chk_eq("shortfall", o_shortfall, e.shortfall);
                        if (e.exp_cyc >= 0) chk_eq("done_cycle", cyc, e.exp_cyc);
                    end
                end
            end
            prev_stall = o_coin_valid && !i_coin_ready;
            prev_coin  = o_return_coin;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) i_coin_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_stocks(input string tag);
        chk_eq({tag, "_stock0"}, o_stock0, m_stock[0]);
        chk_eq({tag, "_stock1"}, o_stock1, m_stock[1]);
        chk_eq({tag, "_stock2"}, o_stock2, m_stock[2]);
    endtask

    // Reference: greedy over denominations, highest first, with finite stock
    task automatic start_req(input int unsigned amt, input bit timed);
        int          n = 0;
        int          guard = 0;
        int unsigned rem = amt;
        bit          found;
        exp_t        e;
        while (!o_req_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!o_req_ready) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: got ready=0 expected 1");
        end
        do begin
            found = 1'b0;
            for (int d = 2; d >= 0; d--) begin
                if (!found && rem >= coin_val[d] && m_stock[d] > 0) begin
                    found = 1'b1;
                    rem -= coin_val[d];
                    m_stock[d]--;
                    e.is_done   = 1'b0;
                    e.coin      = 3'(1 << d);
                    e.shortfall = 0;
                    e.exp_cyc   = timed ? cyc + 2 + 2 * n : -1;
                    sb.push_back(e);
                    n++;
                end
            end
        end while (found);
        e.is_done   = 1'b1;
        e.coin      = 3'b000;
        e.shortfall = rem;
        e.exp_cyc   = timed ? cyc + 2 + 2 * n : -1;
        sb.push_back(e);
        i_return_amount = AMT_W'(amt);
        i_req_valid     = 1'b1;
        step();
        i_req_valid     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        chk_eq({tag, "_pending"}, sb.size(), 0);
        sb.delete();
        step();
        check_stocks(tag);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_coin_valid && n < 50) begin
            step();
            n++;
        end
        chk_eq("wait_valid", o_coin_valid, 1);
    endtask

    task automatic refill_idle(input logic [2:0] bits);
        i_refill = bits;
        step();
        i_refill = 3'b000;
        for (int d = 0; d < 3; d++) begin
            if (bits[d] && m_stock[d] < 255) m_stock[d]++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        i_req_valid = 1'b0;
        i_refill    = 3'b000;
        step();
        step();
        reset = 1'b0;
        sb.delete();
        for (int d = 0; d < 3; d++) m_stock[d] = 10;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned amt;
        int          s1;
        reset = 1'b1; i_req_valid = 1'b0; i_return_amount = '0;
        i_coin_ready = 1'b1; i_refill = 3'b000;
        do_reset();

        chk_eq("rst_ready", o_req_ready, 1);
        chk_eq("rst_valid", o_coin_valid, 0);
        chk_eq("rst_done", o_done, 0);
        chk_eq("rst_shortfall", o_shortfall, 0);
        check_stocks("rst");

        start_req(1600, 1'b1);
        wait_done("amt1600");
        chk_eq("amt1600_stock1_is9", o_stock1, 9);

        start_req(0, 1'b1);
        wait_done("amt0");

        start_req(150, 1'b0);
        wait_done("amt150");

        // Chute stalls for 5 cycles; another request during the stall must be ignored
        i_coin_ready = 1'b0;
        start_req(500, 1'b0);
        wait_valid();
        s1 = m_stock[1] + 1;
        for (int k = 0; k < 5; k++) begin
            i_req_valid     = (k == 0);
            i_return_amount = AMT_W'(100);
            step();
            chk_eq("stall_stock1", o_stock1, s1);
            chk_eq("stall_ready_low", o_req_ready, 0);
        end
        i_req_valid  = 1'b0;
        i_coin_ready = 1'b1;
        wait_done("stall");

        i_coin_ready = 1'b0;
        start_req(100, 1'b0);
        wait_valid();
        s1 = o_stock0;
        i_refill     = 3'b001;
        i_coin_ready = 1'b1;
        m_stock[0]++;
        step();
        i_refill = 3'b000;
        chk_eq("refill_cancel_stock0", o_stock0, s1);
        wait_done("refill_cancel");

        do_reset();
        start_req(10000, 1'b0);
        wait_done("drain1000");
        start_req(1000, 1'b0);
        wait_done("no1000");
        chk_eq("no1000_stock1_is8", o_stock1, 8);
        start_req(4000, 1'b0);
        wait_done("drain500");
        start_req(900, 1'b0);
        wait_done("drain100");
        start_req(300, 1'b0);
        wait_done("short300");

        for (int k = 0; k < 260; k++) refill_idle(3'b100);
        chk_eq("sat_stock2", o_stock2, 255);
        refill_idle(3'b111);
        check_stocks("sat");

        i_coin_ready = 1'b0;
        start_req(1500, 1'b0);
        wait_valid();
        reset = 1'b1;
        step();
        chk_eq("midrst_ready", o_req_ready, 1);
        chk_eq("midrst_valid", o_coin_valid, 0);
        chk_eq("midrst_coin", o_return_coin, 0);
        reset = 1'b0;
        sb.delete();
        for (int d = 0; d < 3; d++) m_stock[d] = 10;
        check_stocks("midrst");
        i_coin_ready = 1'b1;
        start_req(100, 1'b0);
        wait_done("after_rst");

        rnd_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) refill_idle(3'($urandom_range(0, 7)));
            amt = $urandom_range(0, 40) * 100;
            if ($urandom_range(0, 3) == 0) amt += $urandom_range(1, 99);
            start_req(amt, 1'b0);
            wait_done("rand");
        end
        rnd_ready    = 1'b0;
        i_coin_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
